// File: rtl/n64_flashram.sv
// FlashRAM save-type register target: decodes the 32-bit command protocol, holds a
// 128-byte page buffer and hands erase/program jobs to the controller CPU.
module n64_flashram #(
  parameter logic [63:0] FLASH_ID  = 64'h1111_8001_00C2_001E,
  parameter int unsigned PAGE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 select,
  input  logic                 read,
  input  logic                 write,
  input  logic [16:0]          address,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata,
  output logic                 read_mode,
  output logic                 op_pending,
  output logic [1:0]           op_type,
  output logic [PAGE_BITS-1:0] op_page,
  input  logic                 op_done,
  input  logic [5:0]           buf_raddr,
  output logic [15:0]          buf_rdata
);

  typedef enum logic [2:0] {
    StRead, StStatus, StId, StEraseArm, StWriteBuf, StProgArm, StBusy
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           status_q, status_d;
  logic [15:0]          cmd_hi_q, cmd_hi_d;
  logic [1:0]           arm_type_q, arm_type_d;
  logic [PAGE_BITS-1:0] arm_page_q, arm_page_d;
  logic                 op_pending_q, op_pending_d;
  logic [1:0]           op_type_q, op_type_d;
  logic [PAGE_BITS-1:0] op_page_q, op_page_d;

  logic [31:0]          cmd;
  logic [PAGE_BITS-1:0] cmd_page;
  logic                 cmd_wr;
  logic                 buf_wr;
  logic [15:0]          buf_mem [64];

  assign cmd      = {cmd_hi_q, wdata};
  assign cmd_page = cmd[PAGE_BITS-1:0];
  // BUSY swallows every command write, including the high-half latch.
  assign cmd_wr   = select & write & address[16] & (state_q != StBusy);
  assign buf_wr   = select & write & ~address[16] &
                    ((state_q == StWriteBuf) | (state_q == StProgArm));

  logic unused_bits;
  assign unused_bits = ^{address[15:7], address[0], cmd[23:PAGE_BITS]};

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    cmd_hi_d     = cmd_hi_q;
    arm_type_d   = arm_type_q;
    arm_page_d   = arm_page_q;
    op_pending_d = op_pending_q;
    op_type_d    = op_type_q;
    op_page_d    = op_page_q;
    if (state_q == StBusy) begin
      if (op_done) begin
        state_d      = StStatus;
        op_pending_d = 1'b0;
        status_d[0]  = 1'b0;
        status_d[3]  = 1'b1;
      end
    end else if (cmd_wr) begin
      if (!address[1]) begin
        cmd_hi_d = wdata;
      end else begin
        case (cmd[31:24])
          8'hF0: begin
            state_d       = StRead;
            status_d[2:1] = 2'b00;
          end
          8'hE1: state_d = StStatus;
          8'h90: state_d = StId;
          8'h4B: begin
            state_d     = StEraseArm;
            arm_type_d  = 2'd0;
            arm_page_d  = {cmd_page[PAGE_BITS-1:7], 7'b0};
            status_d[1] = 1'b1;
          end
          8'h3C: begin
            state_d     = StEraseArm;
            arm_type_d  = 2'd1;
            arm_page_d  = '0;
            status_d[1] = 1'b1;
          end
          8'hB4: begin
            state_d     = StWriteBuf;
            status_d[2] = 1'b1;
          end
          8'hA5: begin
            state_d     = StProgArm;
            arm_type_d  = 2'd2;
            arm_page_d  = cmd_page;
            status_d[2] = 1'b1;
          end
          8'hD2: begin
            if (state_q == StEraseArm || state_q == StProgArm) begin
              state_d      = StBusy;
              op_pending_d = 1'b1;
              op_type_d    = arm_type_q;
              op_page_d    = arm_page_q;
              status_d[0]  = 1'b1;
              status_d[3]  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRead;
      status_q     <= 8'h00;
      cmd_hi_q     <= '0;
      arm_type_q   <= '0;
      arm_page_q   <= '0;
      op_pending_q <= 1'b0;
      op_type_q    <= '0;
      op_page_q    <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      cmd_hi_q     <= cmd_hi_d;
      arm_type_q   <= arm_type_d;
      arm_page_q   <= arm_page_d;
      op_pending_q <= op_pending_d;
      op_type_q    <= op_type_d;
      op_page_q    <= op_page_d;
    end
  end

  // Page buffer is not reset; a same-index read during a write sees the old word.
  always_ff @(posedge clk) begin
    if (buf_wr) buf_mem[address[6:1]] <= wdata;
    buf_rdata <= buf_mem[buf_raddr];
  end

  always_comb begin
    rdata = '0;
    if (select && read) begin
      case (state_q)
        StRead: rdata = '0;
        StId: begin
          case (address[2:1])
            2'd0:    rdata = FLASH_ID[63:48];
            2'd1:    rdata = FLASH_ID[47:32];
            2'd2:    rdata = FLASH_ID[31:16];
            default: rdata = FLASH_ID[15:0];
          endcase
        end
        default: rdata = address[1] ? {8'h00, status_q} : 16'h0000;
      endcase
    end
  end

  assign read_mode  = (state_q == StRead);
  assign op_pending = op_pending_q;
  assign op_type    = op_type_q;
  assign op_page    = op_page_q;

endmodule

// File: doc/n64_flashram.md
Name: n64_flashram

Overview:
- Register-port target for the FlashRAM save type, sitting directly downstream of the PI bridge on the reg bus.
- Decodes the 32-bit FlashRAM command protocol and holds a 128-byte page write buffer.
- Exposes status and ID words and drives the bridge's read-mode flag, which steers PI reads to memory.
- Hands erase and program jobs to the controller CPU through a pending/done handshake; the CPU also reads the page buffer through a second port.

Parameters:
FLASH_ID  64'h1111_8001_00C2_001E  chip ID returned in ID mode, halfword 0 = bits [63:48]
PAGE_BITS  10  width of page index (1024 pages x 128 B = 128 KiB)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
select  input  1  reg bus FlashRAM address window selected
read  input  1  single-cycle reg bus read strobe
write  input  1  single-cycle reg bus write strobe
address  input  17  reg bus byte address, bit16 = command register, bit0 ignored
wdata  input  16  reg bus write data
rdata  output  16  reg bus read data, combinational
read_mode  output  1  high = PI reads go to memory (array read)
op_pending  output  1  erase/program job waiting for CPU
op_type  output  2  0 = sector erase, 1 = chip erase, 2 = page program
op_page  output  PAGE_BITS  target page (sector erase: page of sector start)
op_done  input  1  CPU pulse: job finished
buf_raddr  input  6  CPU page-buffer halfword index
buf_rdata  output  16  page-buffer data, registered, 1-cycle latency

Behaviour:
- Accesses: a strobe is acted on only when select=1; otherwise read/write are ignored.
- Reset values: state READ, read_mode=1, op_pending=0, op_type=0, op_page=0, status=8'h00, cmd_hi=0. Buffer contents are not reset.
- Command write, address[16]=1:
  - address[1]=0 latches cmd_hi <= wdata.
  - address[1]=1 completes the command {cmd_hi, wdata} and decodes it on the same clock.
  - The opcode is cmd[31:24]; the page is cmd[PAGE_BITS-1:0].
- Opcodes, applied in any non-BUSY state:
  - 0xF0 -> READ.
  - 0xE1 -> STATUS.
  - 0x90 -> ID.
  - 0x4B -> ERASE_ARM, with arm_type=0 and arm_page=page & ~7'h7F aligned to a 128-page sector.
  - 0x3C -> ERASE_ARM, with arm_type=1 and arm_page=0.
  - 0xB4 -> WRITE_BUF.
  - 0xA5 -> PROG_ARM, with arm_type=2 and arm_page=page.
  - 0xD2 in ERASE_ARM or PROG_ARM -> BUSY: op_pending=1, op_type/op_page latched from arm, status[0]=1, status[3]=0.
  - 0xD2 in any other state is ignored.
  - Unknown opcodes leave the state unchanged.
- Status bits:
  - ERASE_ARM sets status[1]=1.
  - WRITE_BUF and PROG_ARM set status[2]=1.
  - READ clears status[2:1].
- BUSY state:
  - All command writes are ignored.
  - op_done=1 -> STATUS: op_pending=0, status[0]=0, status[3]=1.
  - op_done outside BUSY is ignored.
- read_mode is 1 only in READ, and updates on the clock edge following the command.
- Buffer write: in WRITE_BUF or PROG_ARM with address[16]=0, a write stores buf[address[6:1]] <= wdata. The index wraps naturally at 64 halfwords.
- Buffer read: a simultaneous CPU read of the same index being written returns the old data.
- rdata:
  - ID: the FLASH_ID halfword selected by address[2:1].
  - STATUS, BUSY, ERASE_ARM, WRITE_BUF, PROG_ARM: address[1]=0 returns 16'h0000, address[1]=1 returns {8'h00, status}.
  - READ: 16'h0000.
  - rdata is valid in the same cycle as the read strobe.
- Reset asserted mid-job (BUSY) aborts: op_pending=0 next cycle, state READ.

Test Plan:
- Reset -> read_mode=1, op_pending=0. Status read at 0x00002 -> 16'h0000.
- Write 0x10000=0xE100, 0x10002=0x0000; read 0x00002 -> 16'h0000; read_mode=0.
- Write cmd 0xB4000000, then 64 halfwords 0xA000+i to 0x00000 upward; then cmd 0xA5000123 and 0xD2000000.
  - Expect op_pending=1, op_type=2, op_page=0x123, status=8'h05.
  - buf_raddr=5 -> buf_rdata=16'hA005 next cycle.
- Cmd 0x4B0001A7 + 0xD2000000 -> op_type=0, op_page=0x180.
  - While pending, cmd 0xF0000000 is ignored and read_mode stays 0.
  - op_done pulse -> op_pending=0, status=8'h0A.
- Cmd 0x90000000; reads at 0x00000/2/4/6 -> 1111, 8001, 00C2, 001E. Cmd 0xD2000000 with nothing armed -> no job.
- Chip erase armed and executed, reset pulsed while BUSY -> op_pending=0, read_mode=1. The same writes with select=0 have no effect.
